// File: rtl/decode_issue.sv
// Decode/issue stage: splits the instruction word, reads operands and flags, stalls on
// pending results, and holds one decoded instruction for the ALU. Option: DECODE_ISSUE_BYPASS_EN.
module decode_issue #(
  parameter int NREGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        wb_flags_en,
  input  logic [3:0]  wb_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  cond,
  output logic [3:0]  opcode,
  output logic        sbit,
  output logic [2:0]  srcontrol,
  output logic [15:0] imvalue,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [3:0]  inflags,
  output logic [3:0]  rd
);

  localparam int DATA_W = 32;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  logic              vld_p1;
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pend_next;
  logic              flags_pending;
  logic              fpend_next;
  logic [3:0]        flags;

  logic [3:0]        d_cond, d_op, d_rd, d_rn, d_rm;
  logic              d_sbit;
  logic              uses_rn, uses_rm, cond_fl, writes_rd, sets_fl;
  logic [DATA_W-1:0] rn_val, rm_val, op1, op2;
  logic [3:0]        flags_in;
  logic [15:0]       pend16, pend_eff;
  logic              fpend_eff;
  logic              hazard, accept;

  assign d_cond = instr[31:28];
  assign d_op   = instr[27:24];
  assign d_sbit = instr[23];
  assign d_rd   = instr[19:16];
  assign d_rn   = instr[15:12];
  assign d_rm   = instr[11:8];

  // Operand-usage classes: which opcodes read rn, rm, or write rd / flags.
  assign uses_rn   = (d_op <= 4'd5) || (d_op == 4'd7) || (d_op == 4'd8) ||
                     (d_op == 4'd9) || (d_op == 4'd10);
  assign uses_rm   = (d_op <= 4'd5) || (d_op == 4'd8) || (d_op == 4'd10);
  assign cond_fl   = (d_cond >= 4'd1) && (d_cond <= 4'd8);
  assign writes_rd = (d_op <= 4'd7) || (d_op == 4'd9);
  assign sets_fl   = d_sbit || (d_op == 4'd8);

  always_comb begin
    rn_val = '0;
    rm_val = '0;
    pend16 = '0;
    pend16[NREGS-1:0] = pending;
    for (int i = 0; i < NREGS; i++) begin
      if (4'(i) == d_rn) rn_val = regs[i];
      if (4'(i) == d_rm) rm_val = regs[i];
    end
  end

`ifdef DECODE_ISSUE_BYPASS_EN
  // A same-cycle writeback both releases the stall and supplies the operand.
  assign pend_eff  = pend16 & ~(wb_en ? (16'd1 << wb_addr) : 16'd0);
  assign fpend_eff = flags_pending && !wb_flags_en;
  assign op1       = (wb_en && (wb_addr == d_rn)) ? wb_data : rn_val;
  assign op2       = (wb_en && (wb_addr == d_rm)) ? wb_data : rm_val;
  assign flags_in  = wb_flags_en ? wb_flags : flags;
`else
  assign pend_eff  = pend16;
  assign fpend_eff = flags_pending;
  assign op1       = rn_val;
  assign op2       = rm_val;
  assign flags_in  = flags;
`endif

  assign hazard   = (pend_eff[d_rn] && uses_rn) || (pend_eff[d_rm] && uses_rm) ||
                    (fpend_eff && cond_fl);
  assign in_ready = !reset && ((state == EMPTY) || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // New reservations are applied after writeback clears so that set wins.
  always_comb begin
    pend_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      pend_next[i] = (pending[i] && !(wb_en && (wb_addr == 4'(i)))) ||
                     (accept && writes_rd && (d_rd == 4'(i)));
    end
    fpend_next = (flags_pending && !wb_flags_en) || (accept && sets_fl);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pending       <= '0;
      flags_pending <= 1'b0;
      flags         <= 4'd0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && (wb_addr == 4'(i))) regs[i] <= wb_data;
      end
      if (wb_flags_en) flags <= wb_flags;
      pending       <= pend_next;
      flags_pending <= fpend_next;
    end
  end

  // ---- issue register (stage p1) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      vld_p1    <= 1'b0;
      cond      <= '0;
      opcode    <= '0;
      sbit      <= 1'b0;
      srcontrol <= '0;
      imvalue   <= '0;
      in1       <= '0;
      in2       <= '0;
      inflags   <= '0;
      rd        <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= FULL;
            vld_p1 <= 1'b1;
          end
        end
        FULL: begin
          if (!accept && out_ready) begin
            state  <= EMPTY;
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          state  <= EMPTY;
          vld_p1 <= 1'b0;
        end
      endcase
      if (accept) begin
        cond      <= d_cond;
        opcode    <= d_op;
        sbit      <= d_sbit;
        srcontrol <= instr[22:20];
        imvalue   <= instr[15:0];
        in1       <= op1;
        in2       <= op2;
        inflags   <= flags_in;
        rd        <= d_rd;
      end
    end
  end

  assign out_valid = vld_p1;

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter NREGS, default 16, meaning number of 32-bit architectural registers; 4-bit register indices.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have in_valid  input  1, in_ready  output  1, instr  input  32  fetch-side handshake and instruction.
REQ-005 SHALL have wb_en  input  1, wb_addr  input  4, wb_data  input  32  register writeback port.
REQ-006 SHALL have wb_flags_en  input  1, wb_flags  input  4  flag writeback {N,Z,C,V}.
REQ-007 SHALL have out_valid  output  1, out_ready  input  1  ALU-side handshake.
REQ-008 SHALL have registered outputs cond 4, opcode 4, sbit 1, srcontrol 3, imvalue 16, in1 32, in2 32, inflags 4, rd 4.

Function
REQ-009 SHALL decode instr as cond=[31:28], opcode=[27:24], sbit=[23], srcontrol=[22:20], rd=[19:16], imvalue=[15:0], rn=[15:12], rm=[11:8].
REQ-010 SHALL drive in1=reg[rn], in2=reg[rm], inflags=flag register, sampled at the accept cycle.
REQ-011 SHALL accept an instruction on cycles where in_valid && in_ready; latency accept -> out_valid exactly 1 cycle.
REQ-012 SHALL implement output FSM EMPTY/FULL: EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL->FULL on out_ready with accept or on !out_ready.
REQ-013 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-014 SHALL compute in_ready = (EMPTY || out_ready) && !hazard.
REQ-015 SHALL flag hazard when pending[rn] and opcode in {0000-0101, 0111, 1000, 1001, 1010}, or pending[rm] and opcode in {0000-0101, 1000, 1010}, or flags_pending and cond in 0001-1000.
REQ-016 SHALL set pending[rd] on accept of opcodes 0000-0111 and 1001; clear pending[wb_addr] when wb_en; same-cycle set and clear of one index -> set wins.
REQ-017 SHALL set flags_pending on accept when sbit=1 or opcode=1000; clear on wb_flags_en; same-cycle set and clear -> set wins.
REQ-018 SHALL write reg[wb_addr]=wb_data when wb_en, regardless of pending state.
REQ-019 SHALL update the flag register with wb_flags when wb_flags_en.
REQ-020 SHALL treat opcodes 1011-1110 as non-writing and hazard-free; pass through unchanged.
REQ-021 SHALL never issue two accepts in one cycle; no internal buffering beyond the single output register.

Reset
REQ-022 SHALL, on reset, clear all registers, pending bits, flags_pending, flag register to 0; FSM->EMPTY; out_valid=0; all data outputs 0.
REQ-023 SHALL give reset priority over accept and writeback in the same cycle; an in-flight instruction is discarded.
REQ-024 SHALL hold in_ready=0 during reset.

Configuration
REQ-025 SHALL support macro DECODE_ISSUE_BYPASS_EN.
REQ-026 With DECODE_ISSUE_BYPASS_EN defined: hazard uses pending after same-cycle wb clear; in1/in2/inflags take wb_data/wb_flags when index matches a same-cycle writeback.
REQ-027 Without it: hazard uses pre-clear pending; operands read from storage only; dependent instruction accepted one cycle after writeback.

Verification
REQ-028 Reset, then ADD (opcode 0000, rd=2, rn=0, rm=1) with out_ready=1 -> out_valid next cycle, in1=0, in2=0, pending[2]=1.
REQ-029 wb reg1=0x0000_0005, then SUB rn=1 -> in1=0x0000_0005 on output.
REQ-030 ADD rd=3 issued, then XOR rn=3 -> in_ready=0 until wb_en addr 3; with BYPASS_EN accepted that cycle with in1=wb_data, without it one cycle later.
REQ-031 CMP (opcode 1000) issued, then cond=0001 instruction -> stalled until wb_flags_en; inflags equals written flags (e.g. 4'b0100).
REQ-032 out_ready=0 for 3 cycles with FULL -> outputs unchanged, in_ready=0; out_ready=1 -> next instruction accepted same cycle.
REQ-033 reset asserted while FULL with pending[4]=1 -> next cycle out_valid=0, pending all 0, MOVREG rn=4 accepted immediately.
